// File: rtl/serial_deser_pkg.sv
// rtl/serial_deser_pkg.sv - shared width defaults and helpers for the serial deserializer
package serial_deser_pkg;

    localparam int DESER_DATA_W_DEF = 4;

    typedef logic [DESER_DATA_W_DEF-1:0] deser_word_t;

    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/serial_deser.sv
// rtl/serial_deser.sv - MSB-first serial-to-parallel word collector with one-cycle valid pulse
// Optional partial-word flush is enabled by defining SERIAL_DESER_FLUSH_EN.
module serial_deser
    import serial_deser_pkg::*;
#(
    parameter int DATA_W = DESER_DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              srst_n_i,
    input  logic              data_i,
    input  logic              data_val_i,
`ifdef SERIAL_DESER_FLUSH_EN
    input  logic              flush_i,
`endif
    output logic [DATA_W-1:0] deser_data_o,
    output logic              deser_data_val_o
);

    localparam int                 CNT_W    = cnt_w(DATA_W);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0]  MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};

    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              val_q,   val_d;

    logic [DATA_W-1:0] bit_mask;
    logic [DATA_W-1:0] word;
    logic              complete;
    logic              flush_fire;
    logic              emit;

    always_comb begin
        bit_mask = MSB_MASK >> cnt_q;
        word     = shift_q;
        if (data_val_i) begin
            word = data_i ? (shift_q | bit_mask) : (shift_q & ~bit_mask);
        end
        complete = data_val_i && (cnt_q == LAST_CNT);
`ifdef SERIAL_DESER_FLUSH_EN
        flush_fire = flush_i && ((cnt_q != '0) || data_val_i);
`else
        flush_fire = 1'b0;
`endif
        emit = complete || flush_fire;

        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        val_d   = 1'b0;
        if (emit) begin
            // Clearing the shift register here keeps unreceived LSBs zero on a flush.
            cnt_d   = '0;
            shift_d = '0;
            data_d  = word;
            val_d   = 1'b1;
        end else if (data_val_i) begin
            cnt_d   = cnt_q + CNT_W'(1);
            shift_d = word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            val_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            val_q   <= val_d;
        end
    end

    assign deser_data_o     = data_q;
    assign deser_data_val_o = val_q;

endmodule

// File: tb/tb_serial_deser.sv
// tb/tb_serial_deser.sv - scoreboard bench for serial_deser (flush tests with SERIAL_DESER_FLUSH_EN)
module tb_serial_deser;

    localparam int DW = 4;

    logic          clk_i = 1'b0;
    logic          srst_n_i = 1'b0;
    logic          data_i = 1'b0;
    logic          data_val_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [DW-1:0] deser_data_o;
    logic          deser_data_val_o;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    bit            bits_q[$];
    logic [DW-1:0] last_word = '0;
    bit            mon_en = 1'b0;
    int            pulses = 0;

    always #5 clk_i = ~clk_i;

    serial_deser #(.DATA_W(DW)) dut (
        .clk_i            (clk_i),
        .srst_n_i         (srst_n_i),
        .data_i           (data_i),
        .data_val_i       (data_val_i),
`ifdef SERIAL_DESER_FLUSH_EN
        .flush_i          (flush_i),
`endif
        .deser_data_o     (deser_data_o),
        .deser_data_val_o (deser_data_val_o)
    );

    // Reference: bits accumulate in a list; a full list or a flush of a non-empty list becomes a word.
    task automatic model_edge(input bit rst_n, input bit v, input bit d, input bit f);
        logic [DW-1:0] w;
        if (!rst_n) begin
            bits_q.delete();
            exp_q.delete();
            last_word = '0;
        end else begin
            if (v) bits_q.push_back(d);
`ifndef SERIAL_DESER_FLUSH_EN
            f = 1'b0;
`endif
            if (bits_q.size() == DW || (f && bits_q.size() > 0)) begin
                w = '0;
                for (int i = 0; i < bits_q.size(); i++)
                    if (bits_q[i]) w = w | (DW'(1) << (DW - 1 - i));
                exp_q.push_back(w);
                bits_q.delete();
            end
        end
    endtask

    task automatic drive(input bit rst_n, input bit v, input bit d, input bit f);
        srst_n_i   = rst_n;
        data_val_i = v;
        data_i     = d;
        flush_i    = f;
        @(posedge clk_i);
        #1;
        model_edge(rst_n, v, d, f);
        mon_en = 1'b1;
    endtask

    task automatic send_bit(input bit d, input int gap);
        drive(1'b1, 1'b1, d, 1'b0);
        for (int g = 0; g < gap; g++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int gap);
        for (int i = DW - 1; i >= 0; i--) send_bit(w[i], gap);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Latency is exactly one clock, so any queued word must be on the outputs at this sample.
    always @(negedge clk_i) begin
        if (mon_en) begin
            checks++;
            if (deser_data_val_o !== (exp_q.size() > 0)) begin
                errors++;
                $display("FAIL valid_pulse: got %b expected %b at %0t", deser_data_val_o, exp_q.size() > 0, $time);
            end
            if (exp_q.size() > 0) begin
                last_word = exp_q.pop_front();
                pulses++;
            end
            checks++;
            if (deser_data_o !== last_word) begin
                errors++;
                $display("FAIL data_word: got %b expected %b at %0t", deser_data_o, last_word, $time);
            end
        end
    end

    initial begin
        int p0;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'(i), 1'b0);

        send_word(4'b1011, 0);
        idle(3);

        send_word(4'b0010, 2);
        idle(2);

        p0 = pulses;
        send_word(4'h1, 0);
        send_word(4'h8, 0);
        send_word(4'hF, 0);
        send_word(4'h0, 0);
        idle(2);
        checks++;
        if (pulses - p0 != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 4", pulses - p0);
        end

        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        p0 = pulses;
        send_word(4'b1100, 0);
        idle(2);
        checks++;
        if (pulses - p0 != 1) begin
            errors++;
            $display("FAIL reset_mid_word: got %0d pulses expected 1", pulses - p0);
        end

`ifdef SERIAL_DESER_FLUSH_EN
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        idle(2);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        idle(2);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        idle(2);
        send_bit(1'b1, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        idle(2);
`endif

        for (int c = 0; c < 3000; c++) begin
            bit r, v, f;
            r = ($urandom_range(0, 199) != 0);
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 15) == 0);
            drive(r, v, 1'($urandom), f);
        end
        idle(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d words still expected, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
